// File: rtl/controle_multiciclo_if.sv
// ---------------------------------------------------------------------------
// controle_multiciclo_if
// Bundles the signals exchanged between the multicycle MIPS control FSM and
// its datapath (instruction fields, memory handshake, mux selects, write
// enables and the ULA operation code).
//   master : the control FSM (reads opcode/funct/mem_ready, drives the rest)
//   slave  : the datapath side (drives opcode/funct/mem_ready, reads the rest)
// ---------------------------------------------------------------------------
interface controle_multiciclo_if #(
    parameter int OPC_W = 6,
    parameter int FUN_W = 6
);
    logic [OPC_W-1:0] opcode;
    logic [FUN_W-1:0] funct;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [3:0]       inputULA;
    logic             illegal;
    logic [3:0]       state;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               pc_source, inputULA, illegal, state
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               pc_source, inputULA, illegal, state
    );
endinterface

// File: rtl/controle_multiciclo.sv
// ---------------------------------------------------------------------------
// controle_multiciclo
// Main control FSM of a multicycle MIPS (R-type add/sub/and/or/slt, lw, sw,
// beq, j, addi). Each instruction walks through fetch, decode, execute,
// memory and writeback states; memory accesses stall on mem_ready.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, forces FETCH
//   bus : master side of controle_multiciclo_if (opcode/funct/mem_ready in,
//         datapath selects, write enables, inputULA, illegal, state out)
// ---------------------------------------------------------------------------
module controle_multiciclo #(
    parameter int OPC_W = 6,
    parameter int FUN_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    controle_multiciclo_if.master bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } stateT;

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);

    localparam logic [FUN_W-1:0] FN_ADD = FUN_W'(6'b100000);
    localparam logic [FUN_W-1:0] FN_SUB = FUN_W'(6'b100010);
    localparam logic [FUN_W-1:0] FN_AND = FUN_W'(6'b100100);
    localparam logic [FUN_W-1:0] FN_OR  = FUN_W'(6'b100101);
    localparam logic [FUN_W-1:0] FN_SLT = FUN_W'(6'b101010);

    localparam logic [3:0] ULA_ADD = 4'b0010;
    localparam logic [3:0] ULA_SUB = 4'b0110;
    localparam logic [3:0] ULA_AND = 4'b0000;
    localparam logic [3:0] ULA_OR  = 4'b0001;
    localparam logic [3:0] ULA_SLT = 4'b0111;

    stateT      r_state;
    stateT      w_nextState;
    logic       w_functLegal;
    logic [3:0] w_functUla;

    // State register. Reset drops straight back to FETCH so any instruction
    // in flight is abandoned before it can raise another write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Funct decoder shared by DECODE (is this R-type supported at all?) and
    // EXECUTE (which ULA operation to request).
    always_comb begin
        w_functLegal = 1'b1;
        w_functUla   = ULA_ADD;
        case (bus.funct)
            FN_ADD:  w_functUla = ULA_ADD;
            FN_SUB:  w_functUla = ULA_SUB;
            FN_AND:  w_functUla = ULA_AND;
            FN_OR:   w_functUla = ULA_OR;
            FN_SLT:  w_functUla = ULA_SLT;
            default: w_functLegal = 1'b0;
        endcase
    end

    // Next-state and output decode. Everything defaults to 0 so each state
    // only lists what it asserts; unknown state codes fall into the default
    // branch and return to FETCH with every output low. In FETCH the PC and
    // IR loads follow mem_ready, but are held off while rst is high.
    always_comb begin
        w_nextState       = FETCH;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_source     = 2'b00;
        bus.inputULA      = 4'b0000;
        bus.illegal       = 1'b0;
        case (r_state)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.inputULA  = ULA_ADD;
                bus.pc_write  = bus.mem_ready & ~rst;
                bus.ir_write  = bus.mem_ready & ~rst;
                w_nextState   = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.inputULA  = ULA_ADD;
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (w_functLegal) begin
                            w_nextState = EXECUTE;
                        end else begin
                            bus.illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW: w_nextState = MEM_ADDR;
                    OP_BEQ:       w_nextState = BRANCH;
                    OP_J:         w_nextState = JUMP;
                    OP_ADDI:      w_nextState = ADDI_EXEC;
                    default:      bus.illegal = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.inputULA  = ULA_ADD;
                w_nextState   = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                w_nextState  = bus.mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                w_nextState   = bus.mem_ready ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.inputULA  = w_functUla;
                w_nextState   = R_WB;
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.inputULA      = ULA_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.inputULA  = ULA_ADD;
                w_nextState   = ADDI_WB;
            end
            ADDI_WB: begin
                bus.reg_write = 1'b1;
            end
            default: begin
                w_nextState = FETCH;
            end
        endcase
    end

    assign bus.state = r_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_controle_multiciclo
// Directed bench for the multicycle MIPS control FSM: walks each supported
// instruction through its state sequence and checks state codes and the key
// control outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_controle_multiciclo;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    controle_multiciclo_if #(.OPC_W(6), .FUN_W(6)) bus ();

    controle_multiciclo #(.OPC_W(6), .FUN_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move to 1 unit after the next falling edge, well clear of the rising
    // edge, so inputs can be changed and outputs sampled safely.
    task automatic applyStimulus();
        @(negedge clk);
        #1;
    endtask

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    endtask

    logic [5:0] functTab [5];
    logic [3:0] ulaTab   [5];

    // Directed sequence of instructions with hand-derived expectations.
    initial begin
        checkCount = 0;
        passCount  = 0;
        functTab[0] = 6'b100000; ulaTab[0] = 4'b0010;
        functTab[1] = 6'b100100; ulaTab[1] = 4'b0000;
        functTab[2] = 6'b100101; ulaTab[2] = 4'b0001;
        functTab[3] = 6'b101010; ulaTab[3] = 4'b0111;
        functTab[4] = 6'b100010; ulaTab[4] = 4'b0110;

        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;
        bus.funct     = 6'b100010;
        #2;
        checkOutput("reset state", bus.state, 4'd0);
        checkOutput("reset pc_write", {3'b0, bus.pc_write}, 4'd0);
        checkOutput("reset ir_write", {3'b0, bus.ir_write}, 4'd0);
        checkOutput("reset mem_read", {3'b0, bus.mem_read}, 4'd1);
        checkOutput("reset inputULA", bus.inputULA, 4'b0010);

        // Release reset; FETCH with mem_ready high loads PC and IR.
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("fetch pc_write", {3'b0, bus.pc_write}, 4'd1);
        checkOutput("fetch ir_write", {3'b0, bus.ir_write}, 4'd1);
        checkOutput("fetch inputULA", bus.inputULA, 4'b0010);
        checkOutput("fetch alu_src_b", {2'b0, bus.alu_src_b}, 4'b0001);

        // R-type sub: 0,1,6,7,0
        applyStimulus();
        checkOutput("sub decode state", bus.state, 4'd1);
        checkOutput("decode alu_src_b", {2'b0, bus.alu_src_b}, 4'b0011);
        applyStimulus();
        checkOutput("sub exec state", bus.state, 4'd6);
        checkOutput("sub inputULA", bus.inputULA, 4'b0110);
        checkOutput("sub alu_src_a", {3'b0, bus.alu_src_a}, 4'd1);
        applyStimulus();
        checkOutput("sub rwb state", bus.state, 4'd7);
        checkOutput("sub reg_write", {3'b0, bus.reg_write}, 4'd1);
        checkOutput("sub reg_dst", {3'b0, bus.reg_dst}, 4'd1);
        applyStimulus();
        checkOutput("sub back to fetch", bus.state, 4'd0);

        // FETCH stall while mem_ready is low.
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'b100011;
        #1;
        checkOutput("stall pc_write", {3'b0, bus.pc_write}, 4'd0);
        checkOutput("stall ir_write", {3'b0, bus.ir_write}, 4'd0);
        applyStimulus();
        checkOutput("stall state", bus.state, 4'd0);
        bus.mem_ready = 1'b1;

        // lw with two wait cycles in MEM_READ: 0,1,2,3,3,3,4,0
        applyStimulus();
        checkOutput("lw decode state", bus.state, 4'd1);
        applyStimulus();
        checkOutput("lw memaddr state", bus.state, 4'd2);
        checkOutput("lw alu_src_b", {2'b0, bus.alu_src_b}, 4'b0010);
        bus.mem_ready = 1'b0;
        applyStimulus();
        checkOutput("lw memread state a", bus.state, 4'd3);
        checkOutput("lw i_or_d", {3'b0, bus.i_or_d}, 4'd1);
        checkOutput("lw mem_read", {3'b0, bus.mem_read}, 4'd1);
        applyStimulus();
        checkOutput("lw memread state b", bus.state, 4'd3);
        applyStimulus();
        checkOutput("lw memread state c", bus.state, 4'd3);
        bus.mem_ready = 1'b1;
        applyStimulus();
        checkOutput("lw memwb state", bus.state, 4'd4);
        checkOutput("lw mem_to_reg", {3'b0, bus.mem_to_reg}, 4'd1);
        checkOutput("lw reg_write", {3'b0, bus.reg_write}, 4'd1);
        applyStimulus();
        checkOutput("lw back to fetch", bus.state, 4'd0);

        // sw: 0,1,2,5,0
        bus.opcode = 6'b101011;
        applyStimulus();
        checkOutput("sw decode mem_write", {3'b0, bus.mem_write}, 4'd0);
        applyStimulus();
        checkOutput("sw memaddr state", bus.state, 4'd2);
        checkOutput("sw memaddr mem_write", {3'b0, bus.mem_write}, 4'd0);
        applyStimulus();
        checkOutput("sw memwrite state", bus.state, 4'd5);
        checkOutput("sw mem_write", {3'b0, bus.mem_write}, 4'd1);
        checkOutput("sw mem_read", {3'b0, bus.mem_read}, 4'd0);
        applyStimulus();
        checkOutput("sw back to fetch", bus.state, 4'd0);
        checkOutput("sw fetch mem_write", {3'b0, bus.mem_write}, 4'd0);

        // beq: 0,1,8,0
        bus.opcode = 6'b000100;
        applyStimulus();
        applyStimulus();
        checkOutput("beq state", bus.state, 4'd8);
        checkOutput("beq inputULA", bus.inputULA, 4'b0110);
        checkOutput("beq pc_write_cond", {3'b0, bus.pc_write_cond}, 4'd1);
        checkOutput("beq pc_source", {2'b0, bus.pc_source}, 4'b0001);
        applyStimulus();
        checkOutput("beq back to fetch", bus.state, 4'd0);

        // j: 0,1,9,0
        bus.opcode = 6'b000010;
        applyStimulus();
        applyStimulus();
        checkOutput("j state", bus.state, 4'd9);
        checkOutput("j pc_write", {3'b0, bus.pc_write}, 4'd1);
        checkOutput("j pc_source", {2'b0, bus.pc_source}, 4'b0010);
        applyStimulus();
        checkOutput("j back to fetch", bus.state, 4'd0);

        // addi: 0,1,10,11,0
        bus.opcode = 6'b001000;
        applyStimulus();
        applyStimulus();
        checkOutput("addi exec state", bus.state, 4'd10);
        checkOutput("addi alu_src_b", {2'b0, bus.alu_src_b}, 4'b0010);
        applyStimulus();
        checkOutput("addi wb state", bus.state, 4'd11);
        checkOutput("addi reg_write", {3'b0, bus.reg_write}, 4'd1);
        checkOutput("addi reg_dst", {3'b0, bus.reg_dst}, 4'd0);
        applyStimulus();
        checkOutput("addi back to fetch", bus.state, 4'd0);

        // Every supported funct selects its ULA code in EXECUTE.
        bus.opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            bus.funct = functTab[i];
            applyStimulus();
            applyStimulus();
            checkOutput($sformatf("funct %b state", functTab[i]), bus.state, 4'd6);
            checkOutput($sformatf("funct %b inputULA", functTab[i]), bus.inputULA, ulaTab[i]);
            applyStimulus();
            applyStimulus();
            checkOutput($sformatf("funct %b fetch", functTab[i]), bus.state, 4'd0);
        end

        // Unsupported funct: single-cycle illegal pulse, then FETCH.
        bus.funct = 6'b000000;
        checkOutput("bad funct pre illegal", {3'b0, bus.illegal}, 4'd0);
        applyStimulus();
        checkOutput("bad funct illegal", {3'b0, bus.illegal}, 4'd1);
        applyStimulus();
        checkOutput("bad funct state", bus.state, 4'd0);
        checkOutput("bad funct illegal end", {3'b0, bus.illegal}, 4'd0);

        // Unsupported opcode: illegal with no writes, then FETCH.
        bus.opcode = 6'b111111;
        bus.funct  = 6'b100000;
        applyStimulus();
        checkOutput("bad opcode illegal", {3'b0, bus.illegal}, 4'd1);
        checkOutput("bad opcode reg_write", {3'b0, bus.reg_write}, 4'd0);
        checkOutput("bad opcode mem_write", {3'b0, bus.mem_write}, 4'd0);
        applyStimulus();
        checkOutput("bad opcode state", bus.state, 4'd0);

        // Asynchronous reset in the middle of an R-type EXECUTE.
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100000;
        applyStimulus();
        applyStimulus();
        checkOutput("pre reset state", bus.state, 4'd6);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset state", bus.state, 4'd0);
        checkOutput("async reset reg_write", {3'b0, bus.reg_write}, 4'd0);
        checkOutput("async reset pc_write", {3'b0, bus.pc_write}, 4'd0);
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("after reset state", bus.state, 4'd0);
        checkOutput("after reset ir_write", {3'b0, bus.ir_write}, 4'd1);
        applyStimulus();
        checkOutput("after reset decode", bus.state, 4'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
